// File: rtl/ps2_rx_fifo.sv
// PS/2 keyboard receiver: synchronise and filter the PS/2 lines, deframe 11-bit frames,
// fold E0/F0 prefixes into flags and queue decoded codes in a show-ahead FIFO.
module ps2_rx_fifo #(
   parameter int DEPTH          = 8,
   parameter int SYNC_STAGES    = 2,
   parameter int FILTER_LEN     = 8,
   parameter int TIMEOUT_CYCLES = 100000,
   parameter int PREFIX_DECODE  = 1
) (
   input  logic                       Clock,
   input  logic                       Reset,
   input  logic                       iPs2Clk,
   input  logic                       iPs2Data,
   input  logic                       iRead,
   output logic [7:0]                 oData,
   output logic                       oBreak,
   output logic                       oExtended,
   output logic                       oValid,
   output logic [$clog2(DEPTH+1)-1:0] oCount,
   output logic                       oParityError,
   output logic                       oFramingError,
   output logic                       oOverflow
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);
   localparam int FW = $clog2(FILTER_LEN+1);
   localparam int TW = $clog2(TIMEOUT_CYCLES+1);

   typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

   logic [SYNC_STAGES-1:0] clk_sync, data_sync;
   logic                   clk_s, data_s;
   logic                   filt_clk, filt_prev, sample;
   logic [FW-1:0]          filt_cnt;

   state_t                 state, state_d;
   logic [2:0]             bit_cnt;
   logic [7:0]             shift;
   logic                   par_bit, ext_pend, brk_pend;
   logic [TW-1:0]          tmo_cnt;
   logic                   timeout, good, push, par_err, frm_err, is_e0, is_f0;

   logic [9:0]             mem [DEPTH];
   logic [9:0]             head;
   logic [AW-1:0]          wr_ptr, rd_ptr;
   logic [CW-1:0]          count;
   logic                   full, pop, wr_en, ovf;

   // NOTE: every clocked process uses non-blocking assignments so all flops update together.
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         clk_sync  <= '1;
         data_sync <= '1;
         filt_clk  <= 1'b1;
         filt_prev <= 1'b1;
         filt_cnt  <= '0;
      end else begin
         clk_sync  <= {clk_sync[SYNC_STAGES-2:0], iPs2Clk};
         data_sync <= {data_sync[SYNC_STAGES-2:0], iPs2Data};
         filt_prev <= filt_clk;
         if (clk_s == filt_clk)
            filt_cnt <= '0;
         else if (filt_cnt == FW'(FILTER_LEN-1)) begin
            filt_clk <= clk_s;
            filt_cnt <= '0;
         end else
            filt_cnt <= filt_cnt + 1'b1;
      end
   end

   assign clk_s  = clk_sync[SYNC_STAGES-1];
   assign data_s = data_sync[SYNC_STAGES-1];
   assign sample = filt_prev & ~filt_clk;

   // NOTE: every signal gets a default before the case so no latch is inferred.
   always_comb begin
      state_d = state;
      good    = 1'b0;
      par_err = 1'b0;
      frm_err = 1'b0;
      timeout = (state != IDLE) && (tmo_cnt == TW'(TIMEOUT_CYCLES));
      case (state)
         IDLE:    if (sample && !data_s) state_d = DATA;
         DATA:    if (sample && bit_cnt == 3'd7) state_d = PARITY;
         PARITY:  if (sample) state_d = STOP;
         STOP: begin
            if (sample) begin
               state_d = IDLE;
               if (^{shift, par_bit} == 1'b0) par_err = 1'b1;
               else if (!data_s)             frm_err = 1'b1;
               else                          good    = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
      if (timeout) begin
         state_d = IDLE;
         good    = 1'b0;
         par_err = 1'b0;
         frm_err = 1'b1;
      end
      is_e0 = (PREFIX_DECODE != 0) && (shift == 8'hE0);
      is_f0 = (PREFIX_DECODE != 0) && (shift == 8'hF0);
      push  = good && !is_e0 && !is_f0;
   end

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         state    <= IDLE;
         bit_cnt  <= '0;
         shift    <= '0;
         par_bit  <= 1'b0;
         ext_pend <= 1'b0;
         brk_pend <= 1'b0;
         tmo_cnt  <= '0;
      end else begin
         state <= state_d;
         if (state == IDLE || sample || timeout) tmo_cnt <= '0;
         else                                    tmo_cnt <= tmo_cnt + 1'b1;
         if (sample) begin
            case (state)
               IDLE:    bit_cnt <= '0;
               DATA: begin
                  shift   <= {data_s, shift[7:1]};
                  bit_cnt <= bit_cnt + 1'b1;
               end
               PARITY:  par_bit <= data_s;
               default: ;
            endcase
         end
         // Prefixes only survive until a code, an error or a timeout consumes them.
         if (par_err || frm_err || push) begin
            ext_pend <= 1'b0;
            brk_pend <= 1'b0;
         end else if (good && is_e0)
            ext_pend <= 1'b1;
         else if (good && is_f0)
            brk_pend <= 1'b1;
      end
   end

   assign full  = (count == CW'(DEPTH));
   assign pop   = iRead && (count != '0);
   assign wr_en = push && (!full || pop);
   assign ovf   = push && full && !pop;

   // NOTE: the storage array has no reset; oValid masks whatever it holds until written.
   always_ff @(posedge Clock) begin
      if (wr_en) mem[wr_ptr] <= {ext_pend, brk_pend, shift};
   end

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         wr_ptr        <= '0;
         rd_ptr        <= '0;
         count         <= '0;
         oParityError  <= 1'b0;
         oFramingError <= 1'b0;
         oOverflow     <= 1'b0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + 1'b1;
         if (pop)   rd_ptr <= rd_ptr + 1'b1;
         case ({wr_en, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: ;
         endcase
         oParityError  <= par_err;
         oFramingError <= frm_err;
         oOverflow     <= ovf;
      end
   end

   assign head      = mem[rd_ptr];
   assign oValid    = (count != '0);
   assign oCount    = count;
   assign oData     = oValid ? head[7:0] : 8'h00;
   assign oBreak    = oValid & head[8];
   assign oExtended = oValid & head[9];

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Directed bench for ps2_rx_fifo: one prefix-decoding instance (DEPTH=4) and one raw instance.
module tb_ps2_rx_fifo;

   localparam int DEPTH   = 4;
   localparam int TIMEOUT = 200;
   localparam int HALF    = 20;
   localparam int CW      = $clog2(DEPTH+1);

   logic          Clock = 1'b0;
   logic          Reset;
   logic          ps2_clk, ps2_data, rd, raw_rd;
   logic [7:0]    data, raw_data;
   logic          brk, ext, valid, raw_brk, raw_ext, raw_valid;
   logic [CW-1:0] count, raw_count;
   logic          par_e, frm_e, ovf, raw_par_e, raw_frm_e, raw_ovf;

   int n_pass = 0, n_fail = 0, n_total = 0;
   int pe_cnt = 0, fe_cnt = 0, ov_cnt = 0;

   always #5 Clock = ~Clock;

   ps2_rx_fifo #(.DEPTH(DEPTH), .SYNC_STAGES(2), .FILTER_LEN(8),
                 .TIMEOUT_CYCLES(TIMEOUT), .PREFIX_DECODE(1)) u_dut (
      .Clock(Clock), .Reset(Reset), .iPs2Clk(ps2_clk), .iPs2Data(ps2_data), .iRead(rd),
      .oData(data), .oBreak(brk), .oExtended(ext), .oValid(valid), .oCount(count),
      .oParityError(par_e), .oFramingError(frm_e), .oOverflow(ovf));

   ps2_rx_fifo #(.DEPTH(DEPTH), .SYNC_STAGES(2), .FILTER_LEN(8),
                 .TIMEOUT_CYCLES(TIMEOUT), .PREFIX_DECODE(0)) u_raw (
      .Clock(Clock), .Reset(Reset), .iPs2Clk(ps2_clk), .iPs2Data(ps2_data), .iRead(raw_rd),
      .oData(raw_data), .oBreak(raw_brk), .oExtended(raw_ext), .oValid(raw_valid),
      .oCount(raw_count), .oParityError(raw_par_e), .oFramingError(raw_frm_e),
      .oOverflow(raw_ovf));

   // Pulse monitor: counts high cycles, so a pulse wider than one cycle over-counts.
   always @(negedge Clock) begin
      if (!Reset) begin
         if (par_e) pe_cnt++;
         if (frm_e) fe_cnt++;
         if (ovf)   ov_cnt++;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge Clock);
      #1;
   endtask

   task automatic send_bit(input logic b);
      ps2_data = b;
      tick(HALF);
      ps2_clk = 1'b0;
      tick(HALF);
      ps2_clk = 1'b1;
   endtask

   task automatic send_frame(input logic [7:0] b, input logic bad_par, input logic stop);
      send_bit(1'b0);
      for (int i = 0; i < 8; i++) send_bit(b[i]);
      send_bit((~^b) ^ bad_par);
      send_bit(stop);
      ps2_data = 1'b1;
      tick(HALF);
   endtask

   task automatic send_partial(input logic [7:0] b, input int nbits);
      send_bit(1'b0);
      for (int i = 0; i < nbits; i++) send_bit(b[i]);
      ps2_data = 1'b1;
   endtask

   // Good frame whose push lands on the same posedge as a pop (sample event 11 cycles after the fall).
   task automatic send_frame_with_pop(input logic [7:0] b);
      send_bit(1'b0);
      for (int i = 0; i < 8; i++) send_bit(b[i]);
      send_bit(~^b);
      ps2_data = 1'b1;
      tick(HALF);
      ps2_clk = 1'b0;
      tick(10);
      rd = 1'b1;
      tick(1);
      rd = 1'b0;
      tick(HALF - 11);
      ps2_clk = 1'b1;
      tick(HALF);
   endtask

   task automatic pop_expect(input string tag, input logic [7:0] d, input logic b, input logic e);
      check({tag, "_data"}, data, d);
      check({tag, "_brk"}, brk, b);
      check({tag, "_ext"}, ext, e);
      rd = 1'b1;
      tick(1);
      rd = 1'b0;
   endtask

   task automatic raw_pop_expect(input string tag, input logic [7:0] d);
      check({tag, "_data"}, raw_data, d);
      check({tag, "_flags"}, {raw_brk, raw_ext}, 2'b00);
      raw_rd = 1'b1;
      tick(1);
      raw_rd = 1'b0;
   endtask

   task automatic do_reset();
      Reset = 1'b1;
      tick(2);
      Reset = 1'b0;
      tick(3);
   endtask

   initial begin
      Reset    = 1'b1;
      ps2_clk  = 1'b1;
      ps2_data = 1'b1;
      rd       = 1'b0;
      raw_rd   = 1'b0;
      tick(3);
      check("rst_valid", valid, 1'b0);
      check("rst_count", count, '0);
      check("rst_data", data, 8'h00);
      check("rst_flags", {brk, ext}, 2'b00);
      check("rst_pulses", {par_e, frm_e, ovf}, 3'b000);
      Reset = 1'b0;
      tick(5);

      // Single plain frame, then pop.
      send_frame(8'h1C, 1'b0, 1'b1);
      check("f1c_valid", valid, 1'b1);
      check("f1c_count", count, 3'd1);
      pop_expect("f1c", 8'h1C, 1'b0, 1'b0);
      check("f1c_empty_valid", valid, 1'b0);
      check("f1c_empty_count", count, 3'd0);

      // Break code.
      send_frame(8'hF0, 1'b0, 1'b1);
      send_frame(8'h1C, 1'b0, 1'b1);
      check("brk_count", count, 3'd1);
      pop_expect("brk", 8'h1C, 1'b1, 1'b0);

      // Extended break, decoded and raw.
      do_reset();
      send_frame(8'hE0, 1'b0, 1'b1);
      send_frame(8'hF0, 1'b0, 1'b1);
      send_frame(8'h74, 1'b0, 1'b1);
      check("ext_count", count, 3'd1);
      pop_expect("ext", 8'h74, 1'b1, 1'b1);
      check("raw_count", raw_count, 3'd3);
      raw_pop_expect("raw0", 8'hE0);
      raw_pop_expect("raw1", 8'hF0);
      raw_pop_expect("raw2", 8'h74);

      // Parity error, framing error, both faults, then recovery.
      send_frame(8'h1C, 1'b1, 1'b1);
      check("par_pulse", pe_cnt, 1);
      check("par_count", count, 3'd0);
      send_frame(8'h1C, 1'b0, 1'b0);
      check("frm_pulse", fe_cnt, 1);
      check("frm_par_unchanged", pe_cnt, 1);
      send_frame(8'h1C, 1'b1, 1'b0);
      check("both_par", pe_cnt, 2);
      check("both_frm", fe_cnt, 1);
      send_frame(8'h32, 1'b0, 1'b1);
      check("rec_count", count, 3'd1);
      pop_expect("rec", 8'h32, 1'b0, 1'b0);

      // Timeout clears a pending F0.
      send_frame(8'hF0, 1'b0, 1'b1);
      send_partial(8'h1C, 5);
      tick(TIMEOUT + 60);
      check("tmo_pulse", fe_cnt, 2);
      check("tmo_count", count, 3'd0);
      send_frame(8'h1C, 1'b0, 1'b1);
      check("tmo_next_count", count, 3'd1);
      pop_expect("tmo_next", 8'h1C, 1'b0, 1'b0);

      // Overflow and simultaneous push/pop at full.
      do_reset();
      send_frame(8'h11, 1'b0, 1'b1);
      send_frame(8'h22, 1'b0, 1'b1);
      send_frame(8'h33, 1'b0, 1'b1);
      send_frame(8'h44, 1'b0, 1'b1);
      check("full_count", count, 3'd4);
      check("full_no_ovf", ov_cnt, 0);
      send_frame(8'h55, 1'b0, 1'b1);
      check("ovf_pulse", ov_cnt, 1);
      check("ovf_count", count, 3'd4);
      check("ovf_head", data, 8'h11);
      send_frame_with_pop(8'h66);
      check("pp_count", count, 3'd4);
      check("pp_no_ovf", ov_cnt, 1);
      pop_expect("rd0", 8'h22, 1'b0, 1'b0);
      pop_expect("rd1", 8'h33, 1'b0, 1'b0);
      pop_expect("rd2", 8'h44, 1'b0, 1'b0);
      pop_expect("rd3", 8'h66, 1'b0, 1'b0);
      check("drain_count", count, 3'd0);

      // Reset in the middle of a frame.
      send_frame(8'h1C, 1'b0, 1'b1);
      send_partial(8'h5A, 4);
      Reset = 1'b1;
      #2;
      check("mid_rst_valid", valid, 1'b0);
      check("mid_rst_count", count, 3'd0);
      check("mid_rst_data", data, 8'h00);
      tick(2);
      Reset = 1'b0;
      tick(5);
      check("mid_rst_pulses", {par_e, frm_e, ovf}, 3'b000);
      send_frame(8'h5A, 1'b0, 1'b1);
      check("mid_rst_next_count", count, 3'd1);
      check("mid_rst_errs", pe_cnt + fe_cnt, 4);
      pop_expect("mid_rst_next", 8'h5A, 1'b0, 1'b0);

      // 3-cycle glitch on the PS/2 clock with data low must not start a frame.
      ps2_data = 1'b0;
      tick(5);
      ps2_clk = 1'b0;
      tick(3);
      ps2_clk = 1'b1;
      tick(5);
      ps2_data = 1'b1;
      tick(TIMEOUT + 60);
      check("glitch_frm", fe_cnt, 2);
      check("glitch_count", count, 3'd0);
      send_frame(8'h29, 1'b0, 1'b1);
      pop_expect("glitch_next", 8'h29, 1'b0, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
